// File: rtl/dmem_bank_ctrl.sv
// Byte-lane data memory behind a valid/ready request port and a backpressured
// response port, with registered read data, wait states and error reporting.
module dmem_bank_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH_LOG = 10,
    parameter int LATENCY   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W/8-1:0] req_sel,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int LANES = DATA_W / 8;
    localparam int LB    = $clog2(LANES);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic [DATA_W-1:0]   mem [0:(1<<DEPTH_LOG)-1];
    logic [DEPTH_LOG-1:0] idx;
    logic [DATA_W-1:0]   lane_mask;
    logic                addr_ok;
    logic                legal;
    logic                accept;

    // Legal lane groups are a power-of-two run of lanes aligned to its own size.
    function automatic logic sel_legal(input logic [LANES-1:0] sel);
        logic             ok;
        logic [LANES-1:0] m;
        ok = 1'b0;
        for (int g = 1; g <= LANES; g = g * 2) begin
            for (int j = 0; j < LANES; j = j + g) begin
                m = '0;
                for (int k = 0; k < LANES; k++) begin
                    if (k >= j && k < j + g) m[k] = 1'b1;
                end
                if (sel == m) ok = 1'b1;
            end
        end
        return ok;
    endfunction

    assign idx       = req_addr[DEPTH_LOG+LB-1:LB];
    assign addr_ok   = ((req_addr >> (DEPTH_LOG + LB)) == '0);
    assign legal     = addr_ok && sel_legal(req_sel);
    assign req_ready = rst_n && ((state == IDLE) || ((state == RESP) && rsp_ready));
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_mask[8*i +: 8] = {8{req_sel[i]}};
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: ;
            WAIT: begin
                cnt_next = cnt - CNT_ONE;
                if (cnt == CNT_ONE) state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // A new acceptance overrides the above, including the RESP hand-off.
        if (accept) begin
            if (LATENCY == 1) begin
                state_next = RESP;
            end else begin
                state_next = WAIT;
                cnt_next   = CNT_LOAD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                err_q   <= !legal;
                rdata_q <= (legal && !req_we) ? (mem[idx] & lane_mask) : '0;
            end
        end
    end

    // Writes commit at acceptance so a back-to-back read sees the new data.
    always_ff @(posedge clk) begin
        if (accept && legal && req_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (req_sel[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: doc/dmem_bank_ctrl.md
Name: dmem_bank_ctrl

Overview:
Parametrised byte-lane data memory with a valid/ready request port, a response port with backpressure and a configurable access latency. It replaces the bare combinational-read data RAM on the CPU's MEM stage: the stage issues one request, then stalls until the matching response arrives. It adds the following over the bare RAM:
- registered read data;
- wait states;
- alignment and range error reporting;
- back-to-back throughput.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8; lanes = DATA_W/8
ADDR_W, 32, byte-address width
DEPTH_LOG, 10, log2 of word count; words = 2**DEPTH_LOG
LATENCY, 1, cycles from acceptance edge to rsp_valid; must be >= 1

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted on an edge where req_valid && req_ready
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  byte address; word index = req_addr[DEPTH_LOG+LB-1:LB], where LB = log2(lanes)
req_sel  in  DATA_W/8  byte-lane enables; lane i maps to data bits [8i+7:8i]
req_wdata  in  DATA_W  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed on an edge where rsp_valid && rsp_ready
rsp_rdata  out  DATA_W  read data; 0 for writes and errored requests
rsp_err  out  1  request was illegal; no memory effect

Behaviour:
- Reset (rst_n low, async): state = IDLE; req_ready = 0 while rst_n is low; rsp_valid = 0, rsp_rdata = 0, rsp_err = 0; wait counter = 0. Memory contents are not reset.
- States:
  - IDLE: req_ready = 1.
  - WAIT: counting wait cycles; req_ready = 0.
  - RESP: rsp_valid = 1; req_ready = rsp_ready.
- Legality, evaluated at acceptance:
  - req_sel must be nonzero.
  - popcount(req_sel) must be a power of two.
  - The set lanes must be contiguous and naturally aligned to their group size. For 32-bit data the legal values are 0001, 0010, 0100, 1000, 0011, 1100, 1111.
  - req_addr bits above word index + LB must be all zero.
  - Any violation: err = 1.
- Acceptance edge, when req_valid && req_ready:
  - Legal write: every lane with req_sel[i] = 1 is written from req_wdata; other lanes are unchanged.
  - Legal read: the full word at the index is captured into the read register, with lanes where req_sel = 0 forced to 0.
  - Error or write: the read register is set to 0.
  - err is captured.
  - If LATENCY == 1, next state = RESP. Otherwise next state = WAIT with counter = LATENCY-1.
- WAIT: counter decrements each cycle; moves to RESP on the edge where counter == 1.
- The response is visible exactly LATENCY cycles after the acceptance edge.
- RESP: rsp_valid, rsp_rdata and rsp_err are held stable until the rsp_ready edge.
  - On the rsp_ready edge with a new req_valid (req_ready = 1 in that cycle): the new request is accepted on the same edge and the FSM follows the acceptance rule. With LATENCY = 1 this gives one transaction per cycle.
  - On the rsp_ready edge without req_valid: return to IDLE; rsp_valid = 0.
- Read-after-write at the same address in back-to-back transactions returns the new data. This holds because the write commits at its acceptance edge, before the later read's acceptance edge.
- Request inputs are sampled only at the acceptance edge; changes at other times are ignored.
- Reset mid-WAIT or mid-RESP: the response is dropped. A write committed at acceptance persists.

Test Plan:
- Reset then single write: rst_n low 3 cycles, then LATENCY=1, write addr 0x10, sel 1111, wdata 0xDEADBEEF -> req_ready = 1 after reset; rsp_valid = 1 one cycle after acceptance, rsp_err = 0, rsp_rdata = 0.
- Byte-masked write then read: after the write above, write addr 0x10, sel 0100, wdata 0x00AA0000; then read addr 0x10, sel 1111 -> rsp_rdata = 0xDEAABEEF. Read with sel 0011 -> 0x0000BEEF.
- Illegal requests: sel 0110 at 0x10; then sel 0000; then addr 0x1000 with DEPTH_LOG = 10 -> each gives rsp_err = 1 and rsp_rdata = 0. A later read of 0x10 is still 0xDEAABEEF.
- Latency and backpressure: LATENCY=3, read 0x10 accepted at edge E -> rsp_valid rises after edge E+2. Hold rsp_ready = 0 for 4 cycles -> rsp_valid and rsp_rdata stay stable and req_ready = 0.
- Throughput: LATENCY=1, rsp_ready tied high, 8 back-to-back writes to 0x0..0x1C (data = index), then 8 back-to-back reads -> one response per cycle, reads return 0..7 in order.
- Reset mid-operation: LATENCY=4, write 0x20 = 0x12345678, assert rst_n low one cycle after acceptance -> rsp_valid never rises. A subsequent read of 0x20 returns 0x12345678.
